// File: rtl/data_mem_responder.sv
// Multi-cycle data memory behind the MEM stage: latches one load/store, waits a
// fixed latency, pulses ready with registered read data and drives stall meanwhile.
module data_mem_responder #(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          write_q;
  logic          mis_q;

  logic          req;
  logic [AW-1:0] idx_in;
  logic          mis_in;
  logic          enter_done;
  logic [AW-1:0] done_idx;
  logic          done_mis;
  logic          done_write;
  logic          addr_unused;

  assign req         = mem_read | mem_write;
  assign idx_in      = addr[AW+1:2];
  assign mis_in      = (addr[1:0] != 2'b00);
  assign addr_unused = &{1'b0, addr[31:AW+2]};
  assign stall       = req & ~ready;

  // With LATENCY = 1 the request goes straight from IDLE to DONE, so the read
  // data and error flag must come from the live inputs rather than the latches.
  always_comb begin
    enter_done = 1'b0;
    done_idx   = idx_q;
    done_mis   = mis_q;
    done_write = write_q;
    if (state == IDLE && req && LATENCY == 1) begin
      enter_done = 1'b1;
      done_idx   = idx_in;
      done_mis   = mis_in;
      done_write = mem_write;
    end else if (state == BUSY && cnt == '0) begin
      enter_done = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      mis_q   <= 1'b0;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i[AW-1:0]] <= '0;
    end else begin
      ready <= enter_done;
      err   <= enter_done & done_mis;
      if (enter_done) begin
        if (done_mis)        rdata <= '0;
        else if (!done_write) rdata <= mem[done_idx];
      end
      case (state)
        IDLE: begin
          if (req) begin
            idx_q   <= idx_in;
            wdata_q <= wdata;
            write_q <= mem_write;
            mis_q   <= mis_in;
            cnt     <= CNT_LOAD;
            state   <= (LATENCY == 1) ? DONE : BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 1'b1;
        end
        DONE: begin
          if (write_q && !mis_q) mem[idx_q] <= wdata_q;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: a word-array reference model predicts
// each completion, a negedge monitor checks ready timing, rdata and err.
module tb_data_mem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        ready, err, stall;

  logic        mr1, mw1;
  logic [31:0] a1, wd1;
  logic [31:0] rd1;
  logic        rdy1, err1, st1;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err), .stall(stall)
  );

  data_mem_responder #(.DEPTH(16), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .mem_read(mr1), .mem_write(mw1),
    .addr(a1), .wdata(wd1), .rdata(rd1), .ready(rdy1), .err(err1), .stall(st1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model [DEPTH];
  logic [31:0] last_rd;
  int          cycle = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: every ready must match the oldest prediction and its due cycle.
  always @(negedge clk) begin
    if (rst === 1'b1 && mon_en) begin
      if (exp_q.size() != 0 && exp_q[0].due < cycle) begin
        mon_e = exp_q.pop_front();
        check("ready_missing", 32'd0, 32'd1);
      end
      if (ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_ready", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("rdata", rdata, mon_e.rdata);
          check("err", {31'd0, err}, {31'd0, mon_e.err});
          check("ready_cycle", cycle, mon_e.due);
        end
      end else begin
        check("err_idle", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic clear_model();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    last_rd = '0;
  endtask

  task automatic do_op(input bit wr, input bit both, input logic [31:0] a,
                       input logic [31:0] d, input bit drop);
    int   idx;
    bit   mis;
    exp_t e;
    idx = int'((a / 4) % DEPTH);
    mis = (a % 4) != 0;
    @(negedge clk);
    mem_read  = !wr || both;
    mem_write = wr;
    addr      = a;
    wdata     = d;
    if (wr) begin
      if (mis) last_rd = '0;
      else     model[idx] = d;
    end else begin
      last_rd = mis ? 32'd0 : model[idx];
    end
    e.rdata = last_rd;
    e.err   = mis;
    e.due   = cycle + LAT;
    exp_q.push_back(e);
    for (int k = 0; k <= LAT; k++) begin
      #1 check("stall", {31'd0, stall}, (k < LAT && !(drop && k >= 1)) ? 32'd1 : 32'd0);
      if (k == LAT) break;
      @(negedge clk);
      if (drop && k == 0) begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    end
  endtask

  task automatic go_idle(input int gap);
    if (gap > 0) begin
      @(negedge clk);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] a;
    int          idx;
    rst = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    mr1 = 1'b0; mw1 = 1'b0; a1 = '0; wd1 = '0;
    clear_model();
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata", rdata, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_err", {31'd0, err}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;

    do_op(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    go_idle(1);
    do_op(1'b1, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0);
    do_op(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    do_op(1'b1, 1'b1, 32'h40, 32'h12345678, 1'b0);
    do_op(1'b0, 1'b0, 32'h440, 32'h0, 1'b0);
    do_op(1'b1, 1'b0, 32'h22, 32'h0BADF00D, 1'b0);
    do_op(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    go_idle(2);

    // Reset while a store is in flight: nothing may complete or be written.
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h30; wdata = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_rdata", rdata, 32'd0);
    check("async_rst_ready", {31'd0, ready}, 32'd0);
    check("async_rst_err", {31'd0, err}, 32'd0);
    mem_write = 1'b0;
    clear_model();
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    go_idle(2);
    do_op(1'b0, 1'b0, 32'h30, 32'h0, 1'b0);
    go_idle(1);

    for (int n = 0; n < 150; n++) begin
      idx = ($urandom_range(0, 9) == 9) ? DEPTH - 1 : int'($urandom_range(0, 7));
      a = ($urandom << 10) | (idx << 2);
      if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
      do_op($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, a, $urandom,
            $urandom_range(0, 4) == 0);
      go_idle(int'($urandom_range(0, 2)));
    end
    go_idle(1);
    repeat (LAT + 2) @(negedge clk);
    check("queue_drain", exp_q.size(), 32'd0);
    mon_en = 1'b0;

    // LATENCY = 1 instance: store, then a held read of the wrapped alias.
    @(negedge clk);
    mw1 = 1'b1; a1 = 32'h8; wd1 = 32'hCAFEF00D;
    #1;
    check("l1_stall_c0", {31'd0, st1}, 32'd1);
    check("l1_ready_c0", {31'd0, rdy1}, 32'd0);
    @(negedge clk);
    mw1 = 1'b0; mr1 = 1'b1; a1 = 32'h48;
    #1;
    check("l1_wr_ready", {31'd0, rdy1}, 32'd1);
    check("l1_wr_stall", {31'd0, st1}, 32'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      check("l1_ready", {31'd0, rdy1}, (k % 2 == 1) ? 32'd1 : 32'd0);
      check("l1_stall", {31'd0, st1}, (k % 2 == 1) ? 32'd0 : 32'd1);
      if (k % 2 == 1) check("l1_rdata", rd1, 32'hCAFEF00D);
    end
    mr1 = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Multi-cycle data-memory responder serving the MEM stage's load/store requests. It latches one read or write request, models a fixed access latency, returns read data with a one-cycle `ready` pulse and drives `stall` to freeze the pipeline while the access is in flight. It replaces the single-cycle data memory behind the MEM stage and owns the word-addressed storage array.

## Interface

Parameters:
- `DEPTH`, 256: number of 32-bit words; power of two, at least 2.
- `LATENCY`, 3: cycles from request acceptance to `ready`; at least 1.

Ports:
- `clk`  in  1  — single clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `mem_read`  in  1  — load request from the MEM stage.
- `mem_write`  in  1  — store request from the MEM stage.
- `addr`  in  32  — byte address (ALU result).
- `wdata`  in  32  — store data (val2).
- `rdata`  out  32  — load data; registered.
- `ready`  out  1  — one-cycle completion pulse.
- `err`  out  1  — misaligned-access flag; valid only while `ready` = 1.
- `stall`  out  1  — pipeline freeze request; combinational.

## Operation

- Word index is `addr[log2(DEPTH)+1:2]`. Upper address bits are ignored, so addresses wrap modulo DEPTH×4 bytes.
- FSM states:
  - IDLE to BUSY if a request is present and LATENCY > 1.
  - IDLE to DONE if a request is present and LATENCY = 1.
  - BUSY to DONE when the counter reaches 0.
  - DONE to IDLE unconditionally.
- Acceptance happens only in IDLE:
  - `addr`, `wdata` and the operation type are latched.
  - The counter is loaded with LATENCY−2 when LATENCY > 1.
  - BUSY decrements the counter each cycle.
- Write (`mem_write`) takes priority when `mem_read` and `mem_write` are both high; the access is treated as a store.
- Misaligned access (`addr[1:0]` ≠ 0):
  - DONE asserts `err` = 1.
  - No write occurs, and `rdata` is loaded with 0.
- Read: `rdata` is loaded from the array on the transition into DONE. It holds its value until the next read or misaligned completion; a write completion leaves `rdata` unchanged.
- Write: the array word is updated on the clock edge that ends DONE.
- `ready` = 1 only in DONE. `err` = 0 outside DONE.
- `stall` = (`mem_read` | `mem_write`) & ~`ready`.
- The requester holds its request stable until `ready`.
  - If the request drops mid-BUSY, the latched transaction still completes and pulses `ready`.
  - A request held high after `ready` is accepted again in the following IDLE cycle.
- Reset (`rst` = 0), at any time including mid-transaction:
  - FSM goes to IDLE, counter to 0, `rdata` to 0, `ready` to 0, `err` to 0.
  - The whole array is cleared to 0.
  - Any in-flight write is discarded.

## Timing

- Request present in IDLE during cycle 0. `ready` is high in cycle LATENCY and low in cycles 1..LATENCY−1.
- Each transaction occupies LATENCY+1 cycles including the return to IDLE. Back-to-back throughput is one access per LATENCY+1 cycles.
- `stall` is high in cycles 0..LATENCY−1 and low in cycle LATENCY, so the pipeline advances on the edge ending the DONE cycle.
- Read-after-write to the same word returns the new data: the next request is sampled in IDLE, after the write edge.
- Reset values: `rdata` = 0, `ready` = 0, `err` = 0. With no request, `stall` = 0.
- Reset is asynchronous: outputs go to their reset values immediately on `rst` falling, without waiting for a clock edge. Release of `rst` is synchronised by the surrounding design.

## Test plan

- **Reset, then read.** Reset, then read `addr`=0x10 → `rdata`=0 with `ready` in cycle 3 (LATENCY=3). `stall` is high for cycles 0–2 and low in cycle 3.
- **Write then read.** Write 0xDEADBEEF to 0x20 and hold until `ready`, then read 0x20 → `rdata`=0xDEADBEEF. The read's `ready` arrives 4 cycles after the write's `ready`.
- **Simultaneous read/write and wrap-around.** Drive `mem_read`=`mem_write`=1 with 0x12345678 to 0x40 → treated as a write. A subsequent read of 0x40+DEPTH×4 (0x440) returns 0x12345678.
- **Misaligned store.** Write to 0x22 → `ready`=1 and `err`=1 in cycle 3. Word 0x20 is unchanged, and `rdata` is 0.
- **Reset mid-write.** Assert `rst`=0 in cycle 2 of a write of 0xAAAA5555 to 0x30 → `ready` never pulses. The state is IDLE, and a subsequent read of 0x30 returns 0.
- **LATENCY=1 build.** Back-to-back reads with the request held high → `ready` pulses every 2 cycles, and `stall` alternates 1, 0.
